// File: rtl/btn_debounce_repeat_pkg.sv
// Shared types and defaults for the pushbutton conditioner.
// Default timing constants assume clk_oled at 6.25 MHz.
package btn_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PRESSED = 2'd1,
        REPEAT  = 2'd2
    } btn_state_e;

    localparam int DEF_N_SYNC          = 2;
    localparam int DEF_DEBOUNCE_CYCLES = 62500;    // ~10 ms
    localparam int DEF_HOLD_CYCLES     = 3125000;  // ~0.5 s
    localparam int DEF_REPEAT_CYCLES   = 625000;   // ~0.1 s

    // Counter width able to hold 0..max_count-1, never narrower than one bit.
    function automatic int cnt_width(input int max_count);
        return (max_count > 1) ? $clog2(max_count) : 1;
    endfunction

endpackage

// File: rtl/btn_debounce_repeat_if.sv
// Button-side signal bundle: the raw input plus every conditioned output.
// The conditioner uses the slave view, whoever owns the button uses master.
interface btn_debounce_repeat_if;

    logic btn_raw;
    logic btn_level;
    logic press_pulse;
    logic release_pulse;
    logic repeat_pulse;
    logic hold_active;

    modport master (
        output btn_raw,
        input  btn_level,
        input  press_pulse,
        input  release_pulse,
        input  repeat_pulse,
        input  hold_active
    );

    modport slave (
        input  btn_raw,
        output btn_level,
        output press_pulse,
        output release_pulse,
        output repeat_pulse,
        output hold_active
    );

endinterface

// File: rtl/btn_sync_filter.sv
// Synchronizer chain plus debounce counter for one raw button input.
// btn_level is registered; rise/fall are combinational strobes that are high
// in the cycle before btn_level flips, so a parent can register them and stay
// aligned with btn_level.
module btn_sync_filter
    import btn_pkg::*;
#(
    parameter int N_SYNC          = DEF_N_SYNC,
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
    input  logic clk_oled,
    input  logic reset_n,
    input  logic btn_raw,
    output logic btn_level,
    output logic rise,
    output logic fall
);

    localparam int                CNT_W    = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [N_SYNC-1:0] sync_q;
    logic [N_SYNC-1:0] sync_d;
    logic [CNT_W-1:0]  cnt_q;
    logic [CNT_W-1:0]  cnt_d;
    logic              level_q;
    logic              level_d;
    logic              sync_bit;

    assign sync_bit  = sync_q[N_SYNC-1];
    assign btn_level = level_q;

    // Shift the raw input through the metastability chain.
    always_comb begin
        sync_d = {sync_q[N_SYNC-2:0], btn_raw};
    end

    // Count consecutive disagreeing cycles; accept the new level on the last one.
    always_comb begin
        cnt_d   = '0;
        level_d = level_q;
        rise    = 1'b0;
        fall    = 1'b0;
        if (sync_bit != level_q) begin
            if (cnt_q == CNT_LAST) begin
                level_d = ~level_q;
                rise    = ~level_q;
                fall    = level_q;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    // Synchronizer, counter and level registers.
    always_ff @(posedge clk_oled or negedge reset_n) begin
        if (!reset_n) begin
            sync_q  <= '0;
            cnt_q   <= '0;
            level_q <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            cnt_q   <= cnt_d;
            level_q <= level_d;
        end
    end

endmodule

// File: rtl/btn_debounce_repeat.sv
// Pushbutton conditioner: debounced level, press/release pulses and
// optional auto-repeat while held.
// Auto-repeat logic is present only when BTN_AUTOREPEAT_EN is defined;
// otherwise repeat_pulse and hold_active are tied low.
module btn_debounce_repeat
    import btn_pkg::*;
#(
    parameter int N_SYNC          = DEF_N_SYNC,
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int HOLD_CYCLES     = DEF_HOLD_CYCLES,
    parameter int REPEAT_CYCLES   = DEF_REPEAT_CYCLES
) (
    input  logic                 clk_oled,
    input  logic                 reset_n,
    btn_debounce_repeat_if.slave btn
);

    logic level;
    logic rise;
    logic fall;
    logic press_q;
    logic press_d;
    logic release_q;
    logic release_d;

    btn_sync_filter #(
        .N_SYNC          (N_SYNC),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_filter (
        .clk_oled  (clk_oled),
        .reset_n   (reset_n),
        .btn_raw   (btn.btn_raw),
        .btn_level (level),
        .rise      (rise),
        .fall      (fall)
    );

    // Edge strobes become pulses in the same cycle the level flips.
    always_comb begin
        press_d   = rise;
        release_d = fall;
    end

    // Press/release pulse registers.
    always_ff @(posedge clk_oled or negedge reset_n) begin
        if (!reset_n) begin
            press_q   <= 1'b0;
            release_q <= 1'b0;
        end else begin
            press_q   <= press_d;
            release_q <= release_d;
        end
    end

    assign btn.btn_level     = level;
    assign btn.press_pulse   = press_q;
    assign btn.release_pulse = release_q;

`ifdef BTN_AUTOREPEAT_EN

    localparam int               MAX_CYC     = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
    localparam int               TMR_W       = cnt_width(MAX_CYC);
    localparam logic [TMR_W-1:0] HOLD_LAST   = TMR_W'(HOLD_CYCLES - 1);
    localparam logic [TMR_W-1:0] REPEAT_LAST = TMR_W'(REPEAT_CYCLES - 1);

    btn_state_e       state_q;
    btn_state_e       state_d;
    logic [TMR_W-1:0] tmr_q;
    logic [TMR_W-1:0] tmr_d;
    logic             repeat_q;
    logic             repeat_d;
    logic             hold_q;
    logic             hold_d;

    // Hold/repeat sequencing; a release always beats a coincident timer expiry.
    always_comb begin
        state_d  = state_q;
        tmr_d    = tmr_q;
        repeat_d = 1'b0;
        hold_d   = hold_q;
        case (state_q)
            IDLE: begin
                if (rise) begin
                    state_d = PRESSED;
                    tmr_d   = '0;
                end
            end
            PRESSED: begin
                if (fall) begin
                    state_d = IDLE;
                    tmr_d   = '0;
                    hold_d  = 1'b0;
                end else if (tmr_q == HOLD_LAST) begin
                    state_d  = REPEAT;
                    tmr_d    = '0;
                    repeat_d = 1'b1;
                    hold_d   = 1'b1;
                end else begin
                    tmr_d = tmr_q + TMR_W'(1);
                end
            end
            REPEAT: begin
                if (fall) begin
                    state_d = IDLE;
                    tmr_d   = '0;
                    hold_d  = 1'b0;
                end else if (tmr_q == REPEAT_LAST) begin
                    tmr_d    = '0;
                    repeat_d = 1'b1;
                end else begin
                    tmr_d = tmr_q + TMR_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                tmr_d   = '0;
                hold_d  = 1'b0;
            end
        endcase
    end

    // FSM state, timer and repeat output registers.
    always_ff @(posedge clk_oled or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            tmr_q    <= '0;
            repeat_q <= 1'b0;
            hold_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            tmr_q    <= tmr_d;
            repeat_q <= repeat_d;
            hold_q   <= hold_d;
        end
    end

    assign btn.repeat_pulse = repeat_q;
    assign btn.hold_active  = hold_q;

`else

    // Hold and repeat timing have no effect when auto-repeat is left out.
    logic unused_timing_cfg;
    assign unused_timing_cfg = ^{HOLD_CYCLES, REPEAT_CYCLES};

    assign btn.repeat_pulse = 1'b0;
    assign btn.hold_active  = 1'b0;

`endif

endmodule

// File: tb/tb_btn_debounce_repeat.sv
// Self-checking bench for btn_debounce_repeat with short timing
// (N_SYNC=2, DEBOUNCE=4, HOLD=10, REPEAT=3). Expected pulses are queued
// with their cycle number when stimulus is applied and popped by a monitor.
// Expectations follow BTN_AUTOREPEAT_EN the same way the design does.
module tb_btn_debounce_repeat;

`ifdef BTN_AUTOREPEAT_EN
    localparam bit AUTO = 1'b1;
`else
    localparam bit AUTO = 1'b0;
`endif

    typedef enum int {EV_PRESS = 0, EV_RELEASE = 1, EV_REPEAT = 2} ev_kind_e;
    typedef struct {
        int unsigned cyc;
        ev_kind_e    kind;
    } ev_t;

    logic        clk_oled = 1'b0;
    logic        reset_n  = 1'b1;
    int unsigned cyc      = 0;
    int          errors   = 0;
    int          checks   = 0;
    ev_t         exp_q[$];

    btn_debounce_repeat_if bif();

    btn_debounce_repeat #(
        .N_SYNC          (2),
        .DEBOUNCE_CYCLES (4),
        .HOLD_CYCLES     (10),
        .REPEAT_CYCLES   (3)
    ) dut (
        .clk_oled (clk_oled),
        .reset_n  (reset_n),
        .btn      (bif.slave)
    );

    always #5 clk_oled = ~clk_oled;

    always @(posedge clk_oled) cyc++;

    // Monitor: every observed pulse must match the oldest queued expectation.
    always @(negedge clk_oled) begin
        logic [2:0] pulses;
        ev_t        e;
        pulses = {bif.repeat_pulse === 1'b1, bif.release_pulse === 1'b1, bif.press_pulse === 1'b1};
        if (reset_n) begin
            for (int k = 0; k < 3; k++) begin
                if (pulses[k]) begin
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("[TB] FAIL unexpected_pulse: kind %0d at cycle %0d, required no pulse", k, cyc);
                    end else begin
                        e = exp_q.pop_front();
                        if (e.cyc !== cyc || int'(e.kind) !== k) begin
                            errors++;
                            $display("[TB] FAIL pulse_event: got kind %0d at cycle %0d, required kind %0d at cycle %0d",
                                     k, cyc, int'(e.kind), e.cyc);
                        end
                    end
                end
            end
        end
    end

    task automatic push_ev(input ev_kind_e kind, input int unsigned at);
        ev_t e;
        e.cyc  = at;
        e.kind = kind;
        exp_q.push_back(e);
    endtask

    task automatic wait_until(input int unsigned target);
        while (cyc < target) @(negedge clk_oled);
    endtask

    // Returns just after a rising edge; cyc then names that edge.
    task automatic next_edge();
        @(posedge clk_oled);
        #1;
    endtask

    task automatic push_repeats(input int unsigned t0, input int unsigned until_excl);
        if (AUTO) begin
            for (int unsigned t = t0 + 16; t < until_excl; t += 3) push_ev(EV_REPEAT, t);
        end
    endtask

    task automatic test_reset();
        int unsigned t0;
        int unsigned t1;
        int unsigned t2;
        bif.btn_raw = 1'b1;
        #2 reset_n = 1'b0;
        repeat (3) @(negedge clk_oled);
        checks++;
        if ({bif.btn_level, bif.press_pulse, bif.release_pulse, bif.repeat_pulse, bif.hold_active} !== 5'b0) begin
            errors++;
            $display("[TB] FAIL reset_outputs: got %b required 00000",
                     {bif.btn_level, bif.press_pulse, bif.release_pulse, bif.repeat_pulse, bif.hold_active});
        end
        next_edge();
        reset_n = 1'b1;
        t0 = cyc;
        push_ev(EV_PRESS, t0 + 6);
        wait_until(t0 + 5);
        checks++;
        if (bif.btn_level !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_level_early: got %b required 0", bif.btn_level);
        end
        wait_until(t0 + 6);
        checks++;
        if (bif.btn_level !== 1'b1) begin
            errors++;
            $display("[TB] FAIL reset_level_latency: got %b required 1", bif.btn_level);
        end
        // Reset while the button is still held.
        wait_until(t0 + 8);
        #1 reset_n = 1'b0;
        #1;
        checks++;
        if ({bif.btn_level, bif.press_pulse, bif.release_pulse, bif.repeat_pulse, bif.hold_active} !== 5'b0) begin
            errors++;
            $display("[TB] FAIL reset_mid_hold: got %b required 00000",
                     {bif.btn_level, bif.press_pulse, bif.release_pulse, bif.repeat_pulse, bif.hold_active});
        end
        next_edge();
        reset_n = 1'b1;
        t1 = cyc;
        push_ev(EV_PRESS, t1 + 6);
        wait_until(t1 + 6);
        next_edge();
        bif.btn_raw = 1'b0;
        t2 = cyc;
        push_ev(EV_RELEASE, t2 + 6);
        wait_until(t2 + 6);
        checks++;
        if (bif.btn_level !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_rehold_release: got %b required 0", bif.btn_level);
        end
        wait_until(t2 + 10);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("[TB] FAIL reset_missing_events: got %0d pending required 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_glitch();
        int unsigned t0;
        int unsigned t1;
        next_edge();
        bif.btn_raw = 1'b1;
        t0 = cyc;
        repeat (3) next_edge();
        bif.btn_raw = 1'b0;
        for (int unsigned t = t0 + 4; t <= t0 + 14; t += 5) begin
            wait_until(t);
            checks++;
            if (bif.btn_level !== 1'b0) begin
                errors++;
                $display("[TB] FAIL glitch_level: got %b required 0 at cycle %0d", bif.btn_level, cyc);
            end
        end
        // A pulse exactly DEBOUNCE cycles long is the shortest one accepted.
        next_edge();
        bif.btn_raw = 1'b1;
        t1 = cyc;
        push_ev(EV_PRESS, t1 + 6);
        push_ev(EV_RELEASE, t1 + 10);
        repeat (4) next_edge();
        bif.btn_raw = 1'b0;
        wait_until(t1 + 6);
        checks++;
        if (bif.btn_level !== 1'b1) begin
            errors++;
            $display("[TB] FAIL min_pulse_level: got %b required 1", bif.btn_level);
        end
        wait_until(t1 + 16);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("[TB] FAIL glitch_missing_events: got %0d pending required 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_hold_release();
        int unsigned t0;
        next_edge();
        bif.btn_raw = 1'b1;
        t0 = cyc;
        push_ev(EV_PRESS, t0 + 6);
        push_repeats(t0, t0 + 36);
        push_ev(EV_RELEASE, t0 + 36);
        wait_until(t0 + 15);
        checks++;
        if (bif.hold_active !== 1'b0) begin
            errors++;
            $display("[TB] FAIL hold_before_expiry: got %b required 0", bif.hold_active);
        end
        wait_until(t0 + 16);
        checks++;
        if (bif.hold_active !== AUTO) begin
            errors++;
            $display("[TB] FAIL hold_active_start: got %b required %b", bif.hold_active, AUTO);
        end
        wait_until(t0 + 29);
        next_edge();
        bif.btn_raw = 1'b0;
        wait_until(t0 + 35);
        checks++;
        if ({bif.btn_level, bif.hold_active} !== {1'b1, AUTO}) begin
            errors++;
            $display("[TB] FAIL hold_before_release: got %b required %b", {bif.btn_level, bif.hold_active}, {1'b1, AUTO});
        end
        wait_until(t0 + 36);
        checks++;
        if ({bif.btn_level, bif.hold_active, bif.release_pulse} !== 3'b001) begin
            errors++;
            $display("[TB] FAIL release_state: got %b required 001", {bif.btn_level, bif.hold_active, bif.release_pulse});
        end
        wait_until(t0 + 46);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("[TB] FAIL hold_missing_events: got %0d pending required 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_tie();
        int unsigned t0;
        next_edge();
        bif.btn_raw = 1'b1;
        t0 = cyc;
        push_ev(EV_PRESS, t0 + 6);
        push_repeats(t0, t0 + 37);
        push_ev(EV_RELEASE, t0 + 37);
        wait_until(t0 + 30);
        next_edge();
        bif.btn_raw = 1'b0;
        wait_until(t0 + 37);
        checks++;
        if ({bif.release_pulse, bif.repeat_pulse, bif.hold_active} !== 3'b100) begin
            errors++;
            $display("[TB] FAIL tie_release_wins: got %b required 100",
                     {bif.release_pulse, bif.repeat_pulse, bif.hold_active});
        end
        wait_until(t0 + 46);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("[TB] FAIL tie_missing_events: got %0d pending required 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_back_to_back();
        int unsigned t0;
        next_edge();
        bif.btn_raw = 1'b1;
        t0 = cyc;
        push_ev(EV_PRESS, t0 + 6);
        push_ev(EV_RELEASE, t0 + 14);
        push_ev(EV_PRESS, t0 + 22);
        push_ev(EV_RELEASE, t0 + 31);
        wait_until(t0 + 7);
        next_edge();
        bif.btn_raw = 1'b0;
        wait_until(t0 + 15);
        next_edge();
        bif.btn_raw = 1'b1;
        wait_until(t0 + 24);
        next_edge();
        bif.btn_raw = 1'b0;
        wait_until(t0 + 22);
        wait_until(t0 + 31);
        checks++;
        if ({bif.btn_level, bif.release_pulse, bif.hold_active} !== 3'b010) begin
            errors++;
            $display("[TB] FAIL b2b_second_release: got %b required 010",
                     {bif.btn_level, bif.release_pulse, bif.hold_active});
        end
        wait_until(t0 + 40);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("[TB] FAIL b2b_missing_events: got %0d pending required 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        bif.btn_raw = 1'b0;
        test_reset();
        test_glitch();
        test_hold_release();
        test_tie();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
